// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, repeat FSM states and counter width helper
// Contents: default parameter values, rep_state_e, cnt_width().
package debounce_pkg;

  localparam int DEF_N_CH               = 5;
  localparam int DEF_TICK_DIV           = 250000;
  localparam int DEF_STABLE_TICKS       = 3;
  localparam int DEF_REPEAT_DELAY_TICKS = 200;
  localparam int DEF_REPEAT_RATE_TICKS  = 40;
  localparam int DEF_SYNC_STAGES        = 2;

  typedef enum logic [1:0] {
    REL         = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_e;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - button bundle between raw inputs and conditioned outputs
// Signals (all N_CH wide):
//   pb_in, repeat_en                          : driven by master (board side)
//   pb_level, pb_press, pb_release, pb_repeat : driven by slave (conditioner)
interface debounce_multi_if #(
  parameter int N_CH = debounce_pkg::DEF_N_CH
);

  logic [N_CH-1:0] pb_in;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] pb_press;
  logic [N_CH-1:0] pb_release;
  logic [N_CH-1:0] pb_repeat;

  modport master (
    output pb_in, repeat_en,
    input  pb_level, pb_press, pb_release, pb_repeat
  );

  modport slave (
    input  pb_in, repeat_en,
    output pb_level, pb_press, pb_release, pb_repeat
  );

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, stable filter, repeat FSM, pulses
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tick_i       : shared sample tick (one cycle wide)
//   pb_i         : raw asynchronous button input
//   repeat_en_i  : auto-repeat enable, used on tick cycles
//   level_o      : debounced level
//   press_o, release_o, repeat_o : one-cycle event pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS       = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic pb_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int SW      = cnt_width(STABLE_TICKS + 1);
  localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW      = cnt_width(REP_MAX + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] DLY_SAT   = RW'(REPEAT_DELAY_TICKS);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_TICKS - 1);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   level_q, level_d;
  logic [SW-1:0]          stab_q, stab_d;
  rep_state_e             state_q, state_d;
  logic [RW-1:0]          rep_q, rep_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      stab_q    <= '0;
      state_q   <= REL;
      rep_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      stab_q    <= stab_d;
      state_q   <= state_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pb_i};
    level_d   = level_q;
    stab_d    = stab_q;
    state_d   = state_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    if (tick_i) begin
      // Stable filter: a run of disagreeing samples flips the level,
      // any agreeing sample restarts the run.
      if (s != level_q) begin
        if (stab_q == STAB_LAST) begin
          level_d   = ~level_q;
          stab_d    = '0;
          press_d   = ~level_q;
          release_d = level_q;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end else begin
        stab_d = '0;
      end

      // Release wins over any repeat due on the same tick.
      if (release_d) begin
        state_d = REL;
        rep_d   = '0;
      end else begin
        case (state_q)
          REL: begin
            if (press_d) begin
              state_d = HOLD_DELAY;
              rep_d   = '0;
            end
          end
          HOLD_DELAY: begin
            if (rep_q >= DLY_LAST) begin
              if (repeat_en_i) begin
                repeat_d = 1'b1;
                rep_d    = '0;
                state_d  = HOLD_REPEAT;
              end else begin
                rep_d = DLY_SAT;
              end
            end else begin
              rep_d = rep_q + REP_ONE;
            end
          end
          HOLD_REPEAT: begin
            // Disabled ticks freeze the rate count.
            if (repeat_en_i) begin
              if (rep_q >= RATE_LAST) begin
                repeat_d = 1'b1;
                rep_d    = '0;
              end else begin
                rep_d = rep_q + REP_ONE;
              end
            end
          end
          default: begin
            state_d = REL;
            rep_d   = '0;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel push-button conditioner with shared sample tick
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : debounce_multi_if slave (pb_in, repeat_en in; pb_level,
//              pb_press, pb_release, pb_repeat out)
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH               = DEF_N_CH,
  parameter int TICK_DIV           = DEF_TICK_DIV,
  parameter int STABLE_TICKS       = DEF_STABLE_TICKS,
  parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
  input logic             clk,
  input logic             rst,
  debounce_multi_if.slave bus
);

  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [N_CH-1:0] level_w, press_w, release_w, repeat_w;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS       (STABLE_TICKS),
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS),
      .SYNC_STAGES        (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .pb_i        (bus.pb_in[g]),
      .repeat_en_i (bus.repeat_en[g]),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .release_o   (release_w[g]),
      .repeat_o    (repeat_w[g])
    );
  end

  assign bus.pb_level   = level_w;
  assign bus.pb_press   = press_w;
  assign bus.pb_release = release_w;
  assign bus.pb_repeat  = repeat_w;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi against a tick-level model
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int TD   = 4;
  localparam int ST   = 3;
  localparam int DLY  = 5;
  localparam int RATE = 2;
  localparam int SS   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debounce_multi_if #(.N_CH(N)) bus ();

  debounce_multi #(
    .N_CH               (N),
    .TICK_DIV           (TD),
    .STABLE_TICKS       (ST),
    .REPEAT_DELAY_TICKS (DLY),
    .REPEAT_RATE_TICKS  (RATE),
    .SYNC_STAGES        (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
    logic [N-1:0] level;
  } exp_t;

  exp_t expq[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: input seen SS edges late, tick every TD edges after reset,
  // level flips after ST disagreeing ticks, repeats counted in ticks since press.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level;
  int           m_run   [N];
  int           m_phase [N];
  int           m_since [N];
  int           since_rst;

  logic [N-1:0] pb_v, en_v;

  task automatic model_step(input logic r, input logic [N-1:0] pb, input logic [N-1:0] en);
    exp_t         e;
    logic [N-1:0] s;
    bit           was_held;
    e.cyc   = cyc_cnt + 1;
    e.press = '0;
    e.rel   = '0;
    e.rep   = '0;
    if (r) begin
      since_rst = 0;
      hist      = {};
      for (int i = 0; i < SS; i++) hist.push_back('0);
      m_level = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_phase[c] = 0; m_since[c] = 0;
      end
    end else begin
      s = hist[SS-1];
      if ((since_rst % TD) == TD - 1) begin
        for (int c = 0; c < N; c++) begin
          was_held = m_level[c];
          if (s[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == ST) begin
              m_run[c]   = 0;
              m_level[c] = ~m_level[c];
              if (m_level[c]) begin
                e.press[c] = 1'b1;
                m_phase[c] = 0;
                m_since[c] = 0;
              end else begin
                e.rel[c] = 1'b1;
              end
            end
          end else begin
            m_run[c] = 0;
          end
          if (was_held && m_level[c]) begin
            if (m_phase[c] == 0) begin
              m_since[c]++;
              if (m_since[c] >= DLY && en[c]) begin
                e.rep[c]   = 1'b1;
                m_phase[c] = 1;
                m_since[c] = 0;
              end
            end else if (en[c]) begin
              m_since[c]++;
              if (m_since[c] >= RATE) begin
                e.rep[c]   = 1'b1;
                m_since[c] = 0;
              end
            end
          end
        end
      end
      hist.push_front(pb);
      void'(hist.pop_back());
      since_rst++;
    end
    e.level = m_level;
    if ((e.press | e.rel | e.rep) != '0) expq.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] pb, input logic [N-1:0] en);
    rst           = r;
    bus.pb_in     = pb;
    bus.repeat_en = en;
    model_step(r, pb, en);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, pb_v, en_v);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Event bookkeeping for directed checks, filled from the DUT outputs.
  int cnt_press [N];
  int cnt_rel   [N];
  int cnt_rep   [N];
  int last_press[N];
  int last_rel  [N];
  int rep_win   [N];
  int first_rep [N];

  exp_t         mon_e;
  logic [N-1:0] pr, rl, rp;

  always @(negedge clk) begin
    pr = bus.pb_press;
    rl = bus.pb_release;
    rp = bus.pb_repeat;
    if (expq.size() > 0 && expq[0].cyc < cyc_cnt) begin
      mon_e = expq.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missed_pulse cyc=%0d: got none, required press=%h rel=%h rep=%h",
               mon_e.cyc, mon_e.press, mon_e.rel, mon_e.rep);
    end
    if ((pr | rl | rp) != '0) begin
      n_vec++;
      if (expq.size() == 0 || expq[0].cyc != cyc_cnt) begin
        n_miss++;
        $display("FAIL unexpected_pulse cyc=%0d: got press=%h rel=%h rep=%h, required none",
                 cyc_cnt, pr, rl, rp);
      end else begin
        mon_e = expq.pop_front();
        if (pr !== mon_e.press || rl !== mon_e.rel || rp !== mon_e.rep ||
            bus.pb_level !== mon_e.level) begin
          n_miss++;
          $display("FAIL pulse_vector cyc=%0d: got press=%h rel=%h rep=%h lvl=%h, required press=%h rel=%h rep=%h lvl=%h",
                   cyc_cnt, pr, rl, rp, bus.pb_level,
                   mon_e.press, mon_e.rel, mon_e.rep, mon_e.level);
        end
      end
      for (int c = 0; c < N; c++) begin
        if (pr[c] === 1'b1) begin
          cnt_press[c]++;
          last_press[c] = cyc_cnt;
          rep_win[c]    = 0;
        end
        if (rl[c] === 1'b1) begin
          cnt_rel[c]++;
          last_rel[c] = cyc_cnt;
        end
        if (rp[c] === 1'b1) begin
          cnt_rep[c]++;
          if (cyc_cnt - last_press[c] <= 20 * TD) begin
            if (rep_win[c] == 0) first_rep[c] = cyc_cnt - last_press[c];
            rep_win[c]++;
          end
        end
      end
    end
  end

  int k, r0, rl0;

  initial begin
    bus.pb_in     = '0;
    bus.repeat_en = '0;
    pb_v          = '0;
    en_v          = '0;
    #1;

    // Reset with all buttons held
    pb_v = '1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pb_v, en_v);
      check("reset_outputs", int'({bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_repeat}), 0);
    end
    k = cyc_cnt + 1;
    run(30);
    for (int c = 0; c < N; c++) check("reset_press_once", cnt_press[c], 1);
    check("reset_press_time", last_press[0] - k, (TD - 1) + (ST - 1) * TD);
    pb_v = '0;
    run(30);
    check("all_released", int'(bus.pb_level), 0);

    // Clean press on ch0
    k = cyc_cnt + 1;
    pb_v[0] = 1'b1;
    run(20);
    check_range("clean_press_latency", last_press[0] - k, SS + (ST - 1) * TD, SS + ST * TD + 1);
    check("clean_press_others", cnt_press[1] + cnt_press[2] + cnt_press[3], 3);
    en_v[0] = 1'b1;

    // Bounce on ch1, then a clean hold
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) pb_v[1] = ~pb_v[1];
      cycle(1'b0, pb_v, en_v);
    end
    check("bounce_no_press", cnt_press[1], 1);
    check("bounce_no_release", cnt_rel[1], 1);
    pb_v[1] = 1'b1;
    run(30);
    check("bounce_then_hold", cnt_press[1], 2);
    pb_v[1] = 1'b0;
    run(20);

    // Auto-repeat on ch2, enabled then disabled
    en_v[2] = 1'b1;
    pb_v[2] = 1'b1;
    run(110);
    check("repeat_count_20_ticks", rep_win[2], 8);
    check("repeat_first_offset", first_rep[2], DLY * TD);
    pb_v[2] = 1'b0;
    run(30);
    en_v[2] = 1'b0;
    r0 = cnt_rep[2];
    pb_v[2] = 1'b1;
    run(110);
    check("repeat_disabled", cnt_rep[2] - r0, 0);
    pb_v[2] = 1'b0;
    run(30);

    // Release ch0 and press ch3 together
    pb_v[0] = 1'b0;
    pb_v[3] = 1'b1;
    run(30);
    check("simul_same_cycle", last_rel[0], last_press[3]);
    check("simul_press_ch3", cnt_press[3], 2);
    r0 = cnt_rep[0];
    run(40);
    check("no_repeat_after_release", cnt_rep[0], r0);

    // Reset while ch2 is auto-repeating
    en_v[2] = 1'b1;
    pb_v[2] = 1'b1;
    run(60);
    check_range("midhold_repeating", rep_win[2], 1, 8);
    rl0 = cnt_rel[2];
    cycle(1'b1, pb_v, en_v);
    check("midhold_level_cleared", int'(bus.pb_level), 0);
    check("midhold_pulses_cleared", int'({bus.pb_press, bus.pb_release, bus.pb_repeat}), 0);
    k = cyc_cnt + 1;
    run(30);
    check("midhold_press_regen", last_press[2] - k, (TD - 1) + (ST - 1) * TD);
    check("midhold_no_release", cnt_rel[2], rl0);
    pb_v = '0;
    run(30);

    // Randomised bouncing, enables and occasional resets
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(29) == 0) pb_v[c] = ~pb_v[c];
      if ($urandom_range(99) == 0) en_v = N'($urandom);
      cycle($urandom_range(799) == 0, pb_v, en_v);
    end

    pb_v = '0;
    en_v = '0;
    run(60);
    check("queue_drained", expq.size(), 0);
    check("final_level", int'(bus.pb_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button conditioner, successor to the single-button debouncer.
- Each channel gets a two-flop (or deeper) synchroniser, a shared slow-tick sampler and a configurable stable-count filter.
- Outputs per channel: a clean level plus one-cycle press, release and auto-repeat pulses.
- Sits between board buttons and control logic (menu stepping, register increment, FSM advance).

Parameters:
- N_CH, 5, number of independent button channels.
- TICK_DIV, 250000, clk cycles per sample tick (2.5 ms at 100 MHz); must be >= 2.
- STABLE_TICKS, 3, consecutive differing samples required to change the debounced level; must be >= 1.
- REPEAT_DELAY_TICKS, 200, ticks from the press event to the first repeat pulse.
- REPEAT_RATE_TICKS, 40, ticks between subsequent repeat pulses.
- SYNC_STAGES, 2, synchroniser depth; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pb_in  in  N_CH  raw asynchronous button inputs.
- repeat_en  in  N_CH  per-channel auto-repeat enable; sampled on ticks.
- pb_level  out  N_CH  debounced level.
- pb_press  out  N_CH  one-cycle pulse on debounced 0->1 transition.
- pb_release  out  N_CH  one-cycle pulse on debounced 1->0 transition.
- pb_repeat  out  N_CH  one-cycle pulse while held with repeat enabled.

Behaviour:
- Reset: one clock only. rst is synchronous and active-high.
  - All of the following clear to 0 on the next edge: synchroniser flops, tick counter, per-channel counters and all outputs.
- Tick generator (shared):
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for the single cycle where the count equals TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after rst deasserts.
- Synchroniser: pb_in passes through SYNC_STAGES flops per channel; the filter sees only the last stage (s).
- Stable filter (per channel, updated only on tick cycles):
  - If s != pb_level, increment stab_cnt.
  - If s == pb_level, clear stab_cnt.
  - When the increment would reach STABLE_TICKS: pb_level toggles on that edge and stab_cnt clears.
  - Any agreeing sample before that restarts the count, so bounces shorter than STABLE_TICKS ticks produce nothing.
- Pulses:
  - Registered; asserted for exactly the one cycle following the tick cycle whose edge changed pb_level.
  - pb_press or pb_release, never both on one channel.
  - pb_level changes on the same edge the pulse rises.
- Repeat FSM (per channel): states REL, HOLD_DELAY, HOLD_REPEAT.
  - REL: on press go to HOLD_DELAY with rep_cnt=0.
  - HOLD_DELAY: on each tick rep_cnt++. At REPEAT_DELAY_TICKS, if repeat_en is set, pulse pb_repeat, clear rep_cnt and go to HOLD_REPEAT. If repeat_en is clear, stay in HOLD_DELAY with rep_cnt saturated.
  - HOLD_REPEAT: every REPEAT_RATE_TICKS ticks pulse pb_repeat while repeat_en is set. If repeat_en is clear, hold the count with no pulse.
  - Release from any hold state: return to REL, clear rep_cnt, suppress pb_repeat in the same cycle as pb_release.
  - pb_press and pb_repeat never coincide.
- Latency: from a stable raw edge to the pulse is SYNC_STAGES cycles plus (STABLE_TICKS-1)*TICK_DIV to STABLE_TICKS*TICK_DIV cycles, plus 1.
- Widths:
  - Tick counter is clog2(TICK_DIV).
  - stab_cnt is clog2(STABLE_TICKS+1).
  - rep_cnt is clog2(max(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS)+1).
  - No counter may overflow; counters saturate where stated.
- Channels are fully independent. Simultaneous events on different channels pulse in the same cycle.
- Reset mid-hold:
  - Outputs drop to 0 on the next edge with no release pulse.
  - A button still held regenerates pb_press after STABLE_TICKS ticks.

Decomposition:
- Package debounce_pkg holds:
  - default constants for the parameters;
  - the repeat FSM state enum (REL, HOLD_DELAY, HOLD_REPEAT);
  - a clog2-based width helper.
- Sub-module debounce_channel contains the synchroniser, stable filter, repeat FSM and pulse registers for one channel.
- The top level holds the shared tick generator and a generate loop over N_CH channels.

Test Plan:
(All scenarios use TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, SYNC_STAGES=2, N_CH=4.)
- Reset: rst=1 for 3 cycles with pb_in=4'hF -> all outputs 0 during reset; first tick 4 cycles after release; pb_press=4'hF exactly once, 3 ticks after synchronised input is seen.
- Clean press: pb_in[0] rises and holds -> pb_level[0] and a 1-cycle pb_press[0] within 2+8..2+12+1 cycles; other channels silent.
- Bounce rejection: toggle pb_in[1] every 5 cycles for 40 cycles -> no pulses; then hold high -> exactly one pb_press[1].
- Auto-repeat: repeat_en[2]=1, hold 20 ticks -> pb_repeat[2] at ticks 5, 7, 9, ... after the press tick (8 pulses); same run with repeat_en=0 -> zero repeats.
- Release and simultaneity: release ch0 and press ch3 in the same cycle -> pb_release[0] and pb_press[3] high in the same cycle; no pb_repeat[0] after release.
- Reset mid-hold: assert rst during HOLD_REPEAT on ch2 -> pb_level[2]=0 next cycle with no release pulse; press regenerated 3 ticks later.
